// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

    // Upper bound of the memory latency parameter and the width of the
    // latency counter that has to hold it.
    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = 4;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Request owner encoding.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;

endpackage

// File: rtl/dm_rr_pick.sv
// Combinational two-way round-robin picker between the M-stage and the
// external requester.
module dm_rr_pick
    import dm_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic ext_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    // A lone requester always wins; on a conflict the side that was not
    // granted last takes its turn.
    always_comb begin
        grant_valid = cpu_req | ext_req;
        grant_owner = OWN_CPU;
        if (cpu_req && ext_req) begin
            grant_owner = (last_owner == OWN_EXT) ? OWN_CPU : OWN_EXT;
        end else if (ext_req) begin
            grant_owner = OWN_EXT;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: M-stage load/store path vs. an external
// master. One access in flight at a time, fixed-latency memory.
//
// Handshake summary:
//   cpu side : cpu_req is level; cpu_stall stays high until the RESP cycle of
//              the CPU's own access, in which cpu_rdata is valid and the
//              pipeline advances.
//   ext side : ext_req is held with stable fields until ext_ack; ext_ack is a
//              single-cycle completion pulse with ext_rdata valid alongside.
//              A request dropped before grant is ignored; after grant it is
//              committed and still acks.
//   mem side : mem_en is a one-cycle issue strobe; mem_rdata is sampled
//              MEM_LAT cycles after the issue cycle.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    // Legal range 1..MEM_LAT_MAX.
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic [3:0]  ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_ack,
    output logic [31:0] ext_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    arb_state_t       state;
    owner_t           owner;
    owner_t           last_owner;
    logic [CNT_W-1:0] cnt;

    logic [3:0]       cmd_we;
    logic [31:0]      cmd_addr;
    logic [31:0]      cmd_wdata;
    logic [31:0]      rdata_q;

    logic             grant_valid;
    logic             grant_owner;

    dm_rr_pick u_pick (
        .cpu_req     (cpu_req),
        .ext_req     (ext_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Main FSM: grant in IDLE, one issue cycle, count out the latency, one
    // response cycle, then back to IDLE (no back-to-back grant).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_EXT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner      <= owner_t'(grant_owner);
                        last_owner <= owner_t'(grant_owner);
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Command register: snapshot of the winner's fields at grant time so the
    // requester may change or drop its inputs afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_we    <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (state == ST_IDLE && grant_valid) begin
            if (grant_owner == OWN_EXT) begin
                cmd_we    <= ext_we;
                cmd_addr  <= ext_addr;
                cmd_wdata <= ext_wdata;
            end else begin
                cmd_we    <= cpu_we;
                cmd_addr  <= cpu_addr;
                cmd_wdata <= cpu_wdata;
            end
        end
    end

    // Latency counter: loaded at issue, counts down through WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == ST_ISSUE) begin
            cnt <= CNT_W'(MEM_LAT);
        end else if (state == ST_WAIT) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Read-data register: captures the memory word in its valid cycle; shared
    // by both response ports.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (state == ST_WAIT && cnt == CNT_W'(1)) begin
            rdata_q <= mem_rdata;
        end
    end

    assign mem_en    = (state == ST_ISSUE);
    assign mem_we    = mem_en ? cmd_we : 4'b0000;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

    assign cpu_rdata = rdata_q;
    assign ext_rdata = rdata_q;
    assign ext_ack   = (state == ST_RESP) && (owner == OWN_EXT);

    // The pipeline only runs in the RESP cycle of its own access; reset
    // releases it unconditionally.
    assign cpu_stall = cpu_req && !reset &&
                       !((state == ST_RESP) && (owner == OWN_CPU));

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: three instances (MEM_LAT 1, 2, 15) share the
// request inputs; each has its own fixed-latency memory model.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic [3:0]  cpu_we = '0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        ext_req = 1'b0;
    logic [3:0]  ext_we = '0;
    logic [31:0] ext_addr = '0;
    logic [31:0] ext_wdata = '0;

    logic [31:0] cpu_rdata_a [3];
    logic        cpu_stall_a [3];
    logic        ext_ack_a   [3];
    logic [31:0] ext_rdata_a [3];
    logic        mem_en_a    [3];
    logic [3:0]  mem_we_a    [3];
    logic [31:0] mem_addr_a  [3];
    logic [31:0] mem_wdata_a [3];
    logic [31:0] mem_rdata_a [3];

    int checks = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    logic [31:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Memory contents seen by every instance.
    function automatic logic [31:0] data_fn(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        if (a == 32'h0000_0040) return 32'hCAFE_F00D;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 15);
        logic [31:0] issue_cyc = 32'hFFFF_0000;
        logic [31:0] rd_word = '0;

        dm_arbiter #(.MEM_LAT(LAT)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .cpu_req   (cpu_req),
            .cpu_we    (cpu_we),
            .cpu_addr  (cpu_addr),
            .cpu_wdata (cpu_wdata),
            .cpu_rdata (cpu_rdata_a[g]),
            .cpu_stall (cpu_stall_a[g]),
            .ext_req   (ext_req),
            .ext_we    (ext_we),
            .ext_addr  (ext_addr),
            .ext_wdata (ext_wdata),
            .ext_ack   (ext_ack_a[g]),
            .ext_rdata (ext_rdata_a[g]),
            .mem_en    (mem_en_a[g]),
            .mem_we    (mem_we_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_wdata (mem_wdata_a[g]),
            .mem_rdata (mem_rdata_a[g])
        );

        // Memory model: data valid only in the cycle LAT after the issue
        // cycle, junk otherwise.
        always @(posedge clk) begin
            if (mem_en_a[g]) begin
                issue_cyc <= cyc;
                rd_word   <= data_fn(mem_addr_a[g]);
            end
        end
        assign mem_rdata_a[g] = (cyc == issue_cyc + 32'(LAT)) ? rd_word
                                                              : {16'h0BAD, cyc[15:0]};
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with cpu_req high to see the stall forced low, check reset values
    // of the MEM_LAT=2 instance, then release into an IDLE cycle.
    task automatic do_reset();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = '0; ext_addr = '0; ext_wdata = '0;
        repeat (2) step();
        chk("rst cpu_stall", 32'(cpu_stall_a[1]), 32'd0);
        chk("rst mem_en",    32'(mem_en_a[1]),    32'd0);
        chk("rst mem_we",    32'(mem_we_a[1]),    32'd0);
        chk("rst mem_addr",  mem_addr_a[1],       32'd0);
        chk("rst mem_wdata", mem_wdata_a[1],      32'd0);
        chk("rst ext_ack",   32'(ext_ack_a[1]),   32'd0);
        chk("rst cpu_rdata", cpu_rdata_a[1],      32'd0);
        chk("rst ext_rdata", ext_rdata_a[1],      32'd0);
        cpu_req = 1'b0;
        reset = 1'b0;
        step();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        creq;
        logic [3:0]  cwe;
        logic [31:0] caddr;
        logic [31:0] cwdata;
        logic        ereq;
        logic [31:0] eaddr;
        logic        x_stall;
        logic        x_en;
        logic [3:0]  x_we;
        logic [31:0] x_addr;
        logic [31:0] x_wdata;
        logic        x_ack;
        logic        x_rd_chk;
        logic [31:0] x_rd;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic creq, input logic [3:0] cwe,
                           input logic [31:0] caddr, input logic [31:0] cwdata,
                           input logic ereq, input logic [31:0] eaddr,
                           input logic xs, input logic xen, input logic [3:0] xwe,
                           input logic [31:0] xaddr, input logic [31:0] xwd,
                           input logic xack, input logic xrc, input logic [31:0] xrd);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
        v.ereq = ereq; v.eaddr = eaddr;
        v.x_stall = xs; v.x_en = xen; v.x_we = xwe; v.x_addr = xaddr;
        v.x_wdata = xwd; v.x_ack = xack; v.x_rd_chk = xrc; v.x_rd = xrd;
        vq.push_back(v);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int got;
        logic [31:0] got_rd;

        // MEM_LAT=2 instance, one vector per cycle.
        // CPU load 0x100 (cycles 0..5)
        add_vec(1, 4'h0, 32'h100, 32'h0, 0, 32'h0,  1, 0, 4'h0, 32'h000, 32'h0, 0, 0, 32'h0);
        add_vec(1, 4'h0, 32'h100, 32'h0, 0, 32'h0,  1, 1, 4'h0, 32'h100, 32'h0, 0, 0, 32'h0);
        add_vec(1, 4'h0, 32'h100, 32'h0, 0, 32'h0,  1, 0, 4'h0, 32'h100, 32'h0, 0, 0, 32'h0);
        add_vec(1, 4'h0, 32'h100, 32'h0, 0, 32'h0,  1, 0, 4'h0, 32'h100, 32'h0, 0, 0, 32'h0);
        add_vec(1, 4'h0, 32'h100, 32'h0, 0, 32'h0,  0, 0, 4'h0, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
        add_vec(0, 4'h0, 32'h100, 32'h0, 0, 32'h0,  0, 0, 4'h0, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
        // CPU store 0x200, we=0011 (cycles 6..11)
        add_vec(1, 4'h3, 32'h200, 32'h12341234, 0, 32'h0, 1, 0, 4'h0, 32'h100, 32'h0, 0, 0, 32'h0);
        add_vec(1, 4'h3, 32'h200, 32'h12341234, 0, 32'h0, 1, 1, 4'h3, 32'h200, 32'h12341234, 0, 0, 32'h0);
        add_vec(1, 4'h3, 32'h200, 32'h12341234, 0, 32'h0, 1, 0, 4'h0, 32'h200, 32'h0, 0, 0, 32'h0);
        add_vec(1, 4'h3, 32'h200, 32'h12341234, 0, 32'h0, 1, 0, 4'h0, 32'h200, 32'h0, 0, 0, 32'h0);
        add_vec(1, 4'h3, 32'h200, 32'h12341234, 0, 32'h0, 0, 0, 4'h0, 32'h200, 32'h0, 0, 0, 32'h0);
        add_vec(0, 4'h0, 32'h0,   32'h0,        0, 32'h0, 0, 0, 4'h0, 32'h200, 32'h0, 0, 0, 32'h0);
        // EXT read 0x40 (cycles 12..17)
        add_vec(0, 4'h0, 32'h0, 32'h0, 1, 32'h40,  0, 0, 4'h0, 32'h200, 32'h0, 0, 0, 32'h0);
        add_vec(0, 4'h0, 32'h0, 32'h0, 1, 32'h40,  0, 1, 4'h0, 32'h040, 32'h0, 0, 0, 32'h0);
        add_vec(0, 4'h0, 32'h0, 32'h0, 1, 32'h40,  0, 0, 4'h0, 32'h040, 32'h0, 0, 0, 32'h0);
        add_vec(0, 4'h0, 32'h0, 32'h0, 1, 32'h40,  0, 0, 4'h0, 32'h040, 32'h0, 0, 0, 32'h0);
        add_vec(0, 4'h0, 32'h0, 32'h0, 1, 32'h40,  0, 0, 4'h0, 32'h040, 32'h0, 1, 1, 32'hCAFEF00D);
        add_vec(0, 4'h0, 32'h0, 32'h0, 0, 32'h40,  0, 0, 4'h0, 32'h040, 32'h0, 0, 0, 32'h0);

        do_reset();

        foreach (vq[i]) begin
            cpu_req = vq[i].creq; cpu_we = vq[i].cwe;
            cpu_addr = vq[i].caddr; cpu_wdata = vq[i].cwdata;
            ext_req = vq[i].ereq; ext_addr = vq[i].eaddr;
            #1;
            chk($sformatf("vec%0d cpu_stall", i), 32'(cpu_stall_a[1]), 32'(vq[i].x_stall));
            chk($sformatf("vec%0d mem_en", i),    32'(mem_en_a[1]),    32'(vq[i].x_en));
            chk($sformatf("vec%0d mem_we", i),    32'(mem_we_a[1]),    32'(vq[i].x_we));
            chk($sformatf("vec%0d mem_addr", i),  mem_addr_a[1],       vq[i].x_addr);
            chk($sformatf("vec%0d ext_ack", i),   32'(ext_ack_a[1]),   32'(vq[i].x_ack));
            if (vq[i].x_en) begin
                chk($sformatf("vec%0d mem_wdata", i), mem_wdata_a[1], vq[i].x_wdata);
            end
            if (vq[i].x_rd_chk) begin
                chk($sformatf("vec%0d cpu_rdata", i), cpu_rdata_a[1], vq[i].x_rd);
                chk($sformatf("vec%0d ext_rdata", i), ext_rdata_a[1], vq[i].x_rd);
            end
            step();
        end

        // Conflict from reset: CPU (cycle 1), EXT (cycle 6), CPU (cycle 11).
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h100;
        ext_req = 1'b1; ext_addr = 32'h40;
        for (int c = 0; c < 15; c++) begin
            logic exp_en;
            #1;
            exp_en = (c == 1) || (c == 6) || (c == 11);
            chk($sformatf("rr c%0d mem_en", c), 32'(mem_en_a[1]), 32'(exp_en));
            if (exp_en) begin
                chk($sformatf("rr c%0d grant addr", c), mem_addr_a[1],
                    (c == 6) ? 32'h40 : 32'h100);
            end
            chk($sformatf("rr c%0d cpu_stall", c), 32'(cpu_stall_a[1]),
                32'(!((c == 4) || (c == 14))));
            chk($sformatf("rr c%0d ext_ack", c), 32'(ext_ack_a[1]), 32'(c == 9));
            if (c == 9) begin
                chk("rr ext_rdata", ext_rdata_a[1], 32'hCAFEF00D);
            end
            step();
        end
        cpu_req = 1'b0; ext_req = 1'b0;

        // Reset in WAIT of an EXT read.
        do_reset();
        ext_req = 1'b1; ext_addr = 32'h40;
        step();                 // ISSUE
        step();                 // WAIT
        #1;
        reset = 1'b1;
        cpu_req = 1'b1;
        #1;
        chk("mid-rst mem_en",    32'(mem_en_a[1]),    32'd0);
        chk("mid-rst mem_we",    32'(mem_we_a[1]),    32'd0);
        chk("mid-rst mem_addr",  mem_addr_a[1],       32'd0);
        chk("mid-rst mem_wdata", mem_wdata_a[1],      32'd0);
        chk("mid-rst ext_ack",   32'(ext_ack_a[1]),   32'd0);
        chk("mid-rst ext_rdata", ext_rdata_a[1],      32'd0);
        chk("mid-rst cpu_stall", 32'(cpu_stall_a[1]), 32'd0);
        for (int n = 0; n < 3; n++) begin
            step();
            chk($sformatf("in-rst ack %0d", n), 32'(ext_ack_a[1]), 32'd0);
        end
        step();
        cpu_req = 1'b0;
        reset = 1'b0;
        got = -1;
        got_rd = '0;
        for (int n = 0; n < 12 && got < 0; n++) begin
            #1;
            if (ext_ack_a[1]) begin
                got = n;
                got_rd = ext_rdata_a[1];
            end else begin
                step();
            end
        end
        chk("post-rst ack cycle", 32'(got), 32'd4);
        chk("post-rst ext_rdata", got_rd, 32'hCAFEF00D);
        ext_req = 1'b0;
        step();
        chk("post-rst ack pulse", 32'(ext_ack_a[1]), 32'd0);

        // CPU load on MEM_LAT=1 / 2 / 15 instances.
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h100;
        for (int c = 0; c < 18; c++) begin
            #1;
            if (c == 2)  chk("lat1 stall c2", 32'(cpu_stall_a[0]), 32'd1);
            if (c == 3)  begin
                chk("lat1 stall c3", 32'(cpu_stall_a[0]), 32'd0);
                chk("lat1 rdata",    cpu_rdata_a[0], 32'hDEADBEEF);
            end
            if (c == 4)  chk("lat2 stall c4", 32'(cpu_stall_a[1]), 32'd0);
            if (c == 16) chk("lat15 stall c16", 32'(cpu_stall_a[2]), 32'd1);
            if (c == 17) begin
                chk("lat15 stall c17", 32'(cpu_stall_a[2]), 32'd0);
                chk("lat15 rdata",     cpu_rdata_a[2], 32'hDEADBEEF);
            end
            step();
        end
        cpu_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shares the single-port data memory between the M-stage load/store path and an external requester (loader/debug master). Accepts one request at a time and arbitrates round-robin on conflict. Drives a fixed-latency synchronous memory and returns read data. Freezes the pipeline through `cpu_stall` while the M-stage access is outstanding or losing arbitration. Sits between the M-stage (byte-enable and store-data replication already applied upstream) and the DM instance.

## Interface
Parameters:
- `MEM_LAT`, default 2: number of cycles from the issue edge to valid `mem_rdata`. Legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  M-stage holds a load or store.
- `cpu_we`  in  4  byte enables; 0000 means load.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data, already lane-replicated.
- `cpu_rdata`  out  32  raw read word; valid in the CPU RESP cycle.
- `cpu_stall`  out  1  freezes F/D/E/M.
- `ext_req`  in  1  external request; held with stable fields until `ext_ack`.
- `ext_we`  in  4  byte enables; 0000 means read.
- `ext_addr`  in  32  byte address.
- `ext_wdata`  in  32  write data.
- `ext_ack`  out  1  one-cycle completion pulse.
- `ext_rdata`  out  32  read word; valid while `ext_ack` is high.
- `mem_en`  out  1  issue strobe to DM.
- `mem_we`  out  4  byte enables; forced to 0 unless `mem_en` is high.
- `mem_addr`  out  32  address to DM.
- `mem_wdata`  out  32  write data to DM.
- `mem_rdata`  in  32  DM read data; valid `MEM_LAT` cycles after the issue cycle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is present, latch the winner's `we`/`addr`/`wdata` into the command register, record the owner, and go to ISSUE.
  - With no request, stay in IDLE.
- Arbitration:
  - A single requester always wins.
  - When both request, the winner is the one not granted last (`last_owner`). `last_owner` resets to EXT, so the CPU wins the first conflict.
  - `last_owner` updates on every grant.
- ISSUE: `mem_en` = 1 and `mem_*` come from the command register. Load the latency counter with `MEM_LAT`, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reads 1, capture `mem_rdata` into the shared rdata register and go to RESP.
- RESP:
  - CPU owner: `cpu_stall` is low this cycle; `cpu_rdata` holds the captured word.
  - EXT owner: `ext_ack` = 1; `ext_rdata` holds the captured word.
  - Always go to IDLE next. There is no back-to-back grant from RESP.
- Stores traverse the same states. Memory commits at the issue edge; the captured rdata is don't-care.
- `cpu_stall` = `cpu_req` AND NOT (state == RESP AND owner == CPU). It is forced to 0 while `reset` is high.
- `cpu_rdata` and `ext_rdata` are both driven from the single rdata register.
- Addresses and data pass through unmodified. There is no alignment check.
- Request withdrawal:
  - A request that is withdrawn before its grant has no effect.
  - `ext_req` dropping after grant is ignored; the access completes and `ext_ack` still pulses.
  - `ext_req` still high in the cycle after `ext_ack` is a new request.

## Timing
- Reset values:
  - state IDLE, owner CPU, `last_owner` EXT, counter 0.
  - command and rdata registers 0.
  - `mem_en` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0.
  - `ext_ack` 0, `cpu_rdata` 0, `ext_rdata` 0, `cpu_stall` 0.
- Uncontended access, with request seen in IDLE at cycle 0:
  - ISSUE in cycle 1.
  - WAIT in cycles 2..`MEM_LAT`+1.
  - RESP in cycle `MEM_LAT`+2.
  - `cpu_stall` is high for `MEM_LAT`+2 cycles.
- A losing requester waits for the full winner sequence plus one IDLE cycle.
- Reset asserted mid-access:
  - Immediate return to IDLE and no ack.
  - A store already issued stays committed in memory.
- Simultaneous `cpu_req` and `ext_req` in IDLE: resolved by round-robin as above.

## Structure
- Package `dm_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the owner encoding (CPU = 0, EXT = 1);
  - constants `MEM_LAT_MAX` = 15 and counter width 4.
- Sub-module `dm_rr_pick` is the combinational two-way round-robin picker. Inputs: `cpu_req`, `ext_req`, `last_owner`. Outputs: `grant_valid`, `grant_owner`.
- The rest is a single FSM plus the command, rdata and counter registers.

## Test plan
1. `MEM_LAT`=2, CPU load of 0x100 with `mem_rdata`=0xDEADBEEF at the valid cycle:
   - `mem_en` pulses in cycle 1;
   - `cpu_stall` is high in cycles 0–3 and low in cycle 4;
   - `cpu_rdata`=0xDEADBEEF in cycle 4.
2. CPU store with `cpu_we`=0011, `cpu_wdata`=0x12341234, addr 0x200:
   - single `mem_en` with `mem_we`=0011 and addr 0x200;
   - `mem_we` is 0 in all other cycles.
3. EXT read alone of 0x40, mem returns 0xCAFEF00D: `ext_ack` is a one-cycle pulse 4 cycles after the request, with `ext_rdata`=0xCAFEF00D.
4. `cpu_req` and `ext_req` both high from reset:
   - CPU is granted first and EXT next;
   - on a second conflict EXT wins (alternation);
   - `cpu_stall` stays high throughout the EXT access.
5. Assert `reset` during WAIT of an EXT read:
   - all outputs go to 0 immediately;
   - no `ext_ack`;
   - the next request after release completes normally.
6. `MEM_LAT`=1 and `MEM_LAT`=15 CPU loads: RESP arrives in cycle 3 and cycle 17 respectively, with correct data.
